// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared widths, header field offsets and scheduler state encoding
package miner_pkg;
   localparam int HDR_W           = 608;
   localparam int HDR_VERSION_LSB = 576;
   localparam int HDR_PREV_LSB    = 320;
   localparam int HDR_MERKLE_LSB  = 64;
   localparam int HDR_BTIME_LSB   = 32;
   localparam int HDR_BITS_LSB    = 0;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      DRAIN,
      REPORT
   } sched_state_t;
endpackage

// File: rtl/miner_found_picker.sv
// rtl/miner_found_picker.sv - lowest-index found-core priority encoder with nonce mux
module miner_found_picker #(
   parameter int N_CORES = 4,
   parameter int IDX_W   = 2
) (
   input  logic [N_CORES-1:0]    core_found,
   input  logic [32*N_CORES-1:0] core_nonce_out,
   output logic                  any,
   output logic [IDX_W-1:0]      idx,
   output logic [31:0]           nonce
);
   // Scan downward so the lowest index found last wins.
   always_comb begin
      any   = 1'b0;
      idx   = '0;
      nonce = '0;
      for (int i = N_CORES - 1; i >= 0; i--) begin
         if (core_found[i]) begin
            any   = 1'b1;
            idx   = IDX_W'(i);
            nonce = core_nonce_out[32*i +: 32];
         end
      end
   end
endmodule

// File: rtl/miner_job_scheduler.sv
// rtl/miner_job_scheduler.sv - job dispatch across N_CORES cores; optional watchdog via MINER_SCHED_WATCHDOG_EN
module miner_job_scheduler
   import miner_pkg::*;
#(
   parameter int N_CORES        = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   localparam int LOG2_N        = $clog2(N_CORES),
   localparam int IDX_W         = (LOG2_N > 0) ? LOG2_N : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [HDR_W-1:0]      job_hdr,
   input  logic [31:0]           job_nonce_base,
   input  logic                  job_abort,
   output logic [HDR_W-1:0]      core_hdr,
   output logic [N_CORES-1:0]    core_start,
   output logic [32*N_CORES-1:0] core_nonce_in,
   output logic                  core_abort,
   input  logic [N_CORES-1:0]    core_done,
   input  logic [N_CORES-1:0]    core_found,
   input  logic [32*N_CORES-1:0] core_nonce_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_found,
   output logic [31:0]           res_nonce,
   output logic [IDX_W-1:0]      res_core,
   output logic                  busy
);
   sched_state_t           state_q;
   logic                   first_q;
   logic                   suppress_q;
   logic [HDR_W-1:0]       core_hdr_q;
   logic [32*N_CORES-1:0]  nonce_in_q, nonce_in_d;
   logic [N_CORES-1:0]     core_start_q;
   logic                   core_abort_q;
   logic                   res_valid_q, res_found_q;
   logic [31:0]            res_nonce_q;
   logic [IDX_W-1:0]       res_core_q;
`ifdef MINER_SCHED_WATCHDOG_EN
   logic [31:0]            wd_cnt_q;
`endif

   logic                   pick_any;
   logic [IDX_W-1:0]       pick_idx;
   logic [31:0]            pick_nonce;

   miner_found_picker #(.N_CORES(N_CORES), .IDX_W(IDX_W)) u_picker (
      .core_found     (core_found),
      .core_nonce_out (core_nonce_out),
      .any            (pick_any),
      .idx            (pick_idx),
      .nonce          (pick_nonce)
   );

   // Each core takes an equal top-bits slice of the nonce space; wrap is intentional.
   always_comb begin
      nonce_in_d = '0;
      for (int i = 0; i < N_CORES; i++) begin
         nonce_in_d[32*i +: 32] = job_nonce_base + (32'(i) << (32 - LOG2_N));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         first_q      <= 1'b0;
         suppress_q   <= 1'b0;
         core_hdr_q   <= '0;
         nonce_in_q   <= '0;
         core_start_q <= '0;
         core_abort_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_found_q  <= 1'b0;
         res_nonce_q  <= '0;
         res_core_q   <= '0;
`ifdef MINER_SCHED_WATCHDOG_EN
         wd_cnt_q     <= '0;
`endif
      end else begin
         core_start_q <= '0;
         core_abort_q <= 1'b0;
         first_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (job_valid) begin
                  core_hdr_q <= job_hdr;
                  nonce_in_q <= nonce_in_d;
                  state_q    <= START;
               end
            end
            START: begin
               if (&core_done) begin
                  core_start_q <= '1;
                  first_q      <= 1'b1;
`ifdef MINER_SCHED_WATCHDOG_EN
                  wd_cnt_q     <= '0;
`endif
                  state_q      <= RUN;
               end
            end
            RUN: begin
`ifdef MINER_SCHED_WATCHDOG_EN
               wd_cnt_q <= wd_cnt_q + 32'd1;
`endif
               if (pick_any) begin
                  res_found_q  <= 1'b1;
                  res_nonce_q  <= pick_nonce;
                  res_core_q   <= pick_idx;
                  suppress_q   <= 1'b0;
                  core_abort_q <= 1'b1;
                  state_q      <= DRAIN;
               end else if (job_abort) begin
                  suppress_q   <= 1'b1;
                  core_abort_q <= 1'b1;
                  state_q      <= DRAIN;
               end
`ifdef MINER_SCHED_WATCHDOG_EN
               else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                  res_found_q  <= 1'b0;
                  res_nonce_q  <= '0;
                  res_core_q   <= '0;
                  suppress_q   <= 1'b0;
                  core_abort_q <= 1'b1;
                  state_q      <= DRAIN;
               end
`endif
               // done is still stale from before the start pulse on the first RUN cycle
               else if (!first_q && (&core_done)) begin
                  res_found_q <= 1'b0;
                  res_nonce_q <= '0;
                  res_core_q  <= '0;
                  res_valid_q <= 1'b1;
                  state_q     <= REPORT;
               end
            end
            DRAIN: begin
               if (&core_done) begin
                  if (suppress_q) begin
                     state_q <= IDLE;
                  end else begin
                     res_valid_q <= 1'b1;
                     state_q     <= REPORT;
                  end
               end
            end
            REPORT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign job_ready     = rst_n && (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign core_hdr      = core_hdr_q;
   assign core_start    = core_start_q;
   assign core_nonce_in = nonce_in_q;
   assign core_abort    = core_abort_q;
   assign res_valid     = res_valid_q;
   assign res_found     = res_found_q;
   assign res_nonce     = res_nonce_q;
   assign res_core      = res_core_q;
endmodule

// File: tb/tb_miner_job_scheduler.sv
// tb/tb_miner_job_scheduler.sv - directed self-checking bench with behavioural core models
module tb_miner_job_scheduler;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          job_valid = 1'b0;
   logic          job_ready;
   logic [607:0]  job_hdr = '0;
   logic [31:0]   job_nonce_base = '0;
   logic          job_abort = 1'b0;
   logic [607:0]  core_hdr;
   logic [3:0]    core_start;
   logic [127:0]  core_nonce_in;
   logic          core_abort;
   logic [3:0]    core_done;
   logic [3:0]    core_found = '0;
   logic [127:0]  core_nonce_out = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          res_found;
   logic [31:0]   res_nonce;
   logic [1:0]    res_core;
   logic          busy;

   logic [3:0]    running;
   logic [3:0]    finish_req = '0;
   int            abort_pulses = 0;
   int            nvec = 0;
   int            nerr = 0;

   localparam logic [607:0] H1 = {19{32'hDEADBEEF}};
   localparam logic [607:0] H2 = {19{32'h12345678}};

   miner_job_scheduler #(.N_CORES(4), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_hdr(job_hdr),
      .job_nonce_base(job_nonce_base), .job_abort(job_abort),
      .core_hdr(core_hdr), .core_start(core_start), .core_nonce_in(core_nonce_in),
      .core_abort(core_abort), .core_done(core_done), .core_found(core_found),
      .core_nonce_out(core_nonce_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
      .res_nonce(res_nonce), .res_core(res_core), .busy(busy)
   );

   always #5 clk = ~clk;

   // Core model: runs from start until abort or a bench-requested finish.
   always @(posedge clk) begin
      if (!rst_n) running <= '0;
      else        running <= core_start | (running & ~finish_req & {4{~core_abort}});
   end
   assign core_done = ~running;

   always @(negedge clk) if (core_abort === 1'b1) abort_pulses++;

   task automatic start_job(input logic [31:0] base);
      @(negedge clk);
      job_valid = 1'b1; job_hdr = H1; job_nonce_base = base;
      @(negedge clk);
      job_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic abort_job();
      @(negedge clk);
      job_abort = 1'b1;
      @(negedge clk);
      job_abort = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; job_valid = 1'b1;
      repeat (2) @(negedge clk);
      nvec++; if (job_ready !== 1'b0) begin nerr++; $display("FAIL reset_job_ready: got %b want 0", job_ready); end
      nvec++; if ({busy, core_start, core_abort, res_valid, res_found} !== 8'h00) begin nerr++;
         $display("FAIL reset_ctrl: got %b want 00000000", {busy, core_start, core_abort, res_valid, res_found}); end
      nvec++; if ({res_nonce, res_core} !== 34'h0) begin nerr++; $display("FAIL reset_res: got %h want 0", {res_nonce, res_core}); end
      nvec++; if (core_hdr !== '0 || core_nonce_in !== '0) begin nerr++; $display("FAIL reset_core_outs: hdr/nonce not zero"); end
      job_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      nvec++; if (job_ready !== 1'b1) begin nerr++; $display("FAIL idle_job_ready: got %b want 1", job_ready); end
   endtask

   task automatic test_nonce_split();
      @(negedge clk);
      job_valid = 1'b1; job_hdr = H1; job_nonce_base = 32'h0000_0000;
      @(negedge clk);
      job_valid = 1'b0;
      nvec++; if ({job_ready, busy} !== 2'b01) begin nerr++; $display("FAIL accept_state: got %b want 01", {job_ready, busy}); end
      nvec++; if (core_nonce_in !== 128'hC0000000_80000000_40000000_00000000) begin nerr++;
         $display("FAIL split_base0: got %h want c0000000800000004000000000000000", core_nonce_in); end
      nvec++; if (core_hdr !== H1) begin nerr++; $display("FAIL hdr_latch: got %h want %h", core_hdr[31:0], H1[31:0]); end
      nvec++; if (core_start !== 4'b0000) begin nerr++; $display("FAIL start_early: got %b want 0000", core_start); end
      @(negedge clk);
      nvec++; if (core_start !== 4'b1111) begin nerr++; $display("FAIL start_pulse: got %b want 1111", core_start); end
      @(negedge clk);
      nvec++; if (core_start !== 4'b0000) begin nerr++; $display("FAIL start_width: got %b want 0000", core_start); end
      abort_job();
      @(negedge clk);
      job_valid = 1'b1; job_hdr = H2; job_nonce_base = 32'hF000_0000;
      @(negedge clk);
      job_valid = 1'b0;
      nvec++; if (core_nonce_in !== 128'hB0000000_70000000_30000000_F0000000) begin nerr++;
         $display("FAIL split_wrap: got %h want b00000007000000030000000f0000000", core_nonce_in); end
      repeat (2) @(negedge clk);
      abort_job();
   endtask

   task automatic test_found_single();
      int a0;
      int cyc;
      start_job(32'h0);
      a0 = abort_pulses;
      @(negedge clk);
      core_found = 4'b0100;
      core_nonce_out = {32'hC0000077, 32'h80001234, 32'h40000066, 32'h00000055};
      @(negedge clk);
      core_found = '0;
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL found1_timeout: res_valid %b want 1", res_valid); end
      nvec++; if (abort_pulses - a0 !== 1) begin nerr++; $display("FAIL found1_abort: got %0d pulses want 1", abort_pulses - a0); end
      nvec++; if ({res_found, res_nonce, res_core} !== {1'b1, 32'h80001234, 2'd2}) begin nerr++;
         $display("FAIL found1_res: got %b %h %0d want 1 80001234 2", res_found, res_nonce, res_core); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      nvec++; if ({res_valid, job_ready} !== 2'b01) begin nerr++; $display("FAIL found1_release: got %b want 01", {res_valid, job_ready}); end
   endtask

   task automatic test_found_multi_abort();
      int cyc;
      start_job(32'h0);
      @(negedge clk);
      core_found = 4'b1010; job_abort = 1'b1;
      core_nonce_out = {32'hC0005555, 32'h8000EEEE, 32'h4000ABCD, 32'h0000FFFF};
      @(negedge clk);
      core_found = '0; job_abort = 1'b0;
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL multi_timeout: res_valid %b want 1", res_valid); end
      nvec++; if ({res_found, res_nonce, res_core} !== {1'b1, 32'h4000ABCD, 2'd1}) begin nerr++;
         $display("FAIL multi_res: got %b %h %0d want 1 4000abcd 1", res_found, res_nonce, res_core); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_exhausted_backpressure();
      int a0;
      int cyc;
      start_job(32'h0);
      a0 = abort_pulses;
      finish_req = 4'hF;
      @(negedge clk);
      finish_req = '0;
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL exh_timeout: res_valid %b want 1", res_valid); end
      nvec++; if ({res_found, res_nonce, res_core} !== 35'h0) begin nerr++;
         $display("FAIL exh_res: got %b %h %0d want 0 0 0", res_found, res_nonce, res_core); end
      nvec++; if (abort_pulses != a0) begin nerr++; $display("FAIL exh_abort: got %0d pulses want 0", abort_pulses - a0); end
      job_valid = 1'b1; job_hdr = H2; job_nonce_base = 32'h1234_0000;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         nvec++; if ({res_valid, res_found, res_nonce, res_core, job_ready} !== {1'b1, 35'h0, 1'b0}) begin nerr++;
            $display("FAIL hold_cycle%0d: valid %b found %b nonce %h core %0d ready %b", k, res_valid, res_found, res_nonce, res_core, job_ready); end
      end
      job_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      @(negedge clk);
      nvec++; if ({res_valid, busy, job_ready} !== 3'b001) begin nerr++; $display("FAIL hold_release: got %b want 001", {res_valid, busy, job_ready}); end
      nvec++; if (core_hdr !== H1) begin nerr++; $display("FAIL hold_hdr: got %h want %h", core_hdr[31:0], H1[31:0]); end
   endtask

   task automatic test_abort();
      int a0;
      logic seen;
      start_job(32'h0);
      a0 = abort_pulses;
      seen = 1'b0;
      @(negedge clk);
      job_abort = 1'b1;
      @(negedge clk);
      job_abort = 1'b0;
      nvec++; if (core_abort !== 1'b1) begin nerr++; $display("FAIL abort_pulse: got %b want 1", core_abort); end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (res_valid === 1'b1) seen = 1'b1;
      end
      nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL abort_no_result: res_valid seen %b want 0", seen); end
      nvec++; if (abort_pulses - a0 !== 1) begin nerr++; $display("FAIL abort_count: got %0d want 1", abort_pulses - a0); end
      nvec++; if ({job_ready, busy} !== 2'b10) begin nerr++; $display("FAIL abort_idle: got %b want 10", {job_ready, busy}); end
   endtask

   initial begin
      test_reset();
      test_nonce_split();
      test_found_single();
      test_found_multi_abort();
      test_exhausted_backpressure();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
